// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int CLA_WIDTH = 32;
  localparam int CLA_CHUNK = 8;

  // Pipeline depth: one stage per CHUNK-bit slice.
  function automatic int cla_nstage(input int width, input int chunk);
    return width / chunk;
  endfunction

  // The slicing only works when slices tile the word and groups tile a slice.
  function automatic bit cla_params_ok(input int width, input int chunk);
    return (chunk >= 4) && (width >= chunk) &&
           ((width % chunk) == 0) && ((chunk % 4) == 0);
  endfunction

endpackage

// File: rtl/cla_chunk.sv
// One CHUNK-bit slice: 4-bit lookahead groups plus lookahead across groups.
module cla_chunk
  import cla_pkg::*;
#(
  parameter int CHUNK = CLA_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  localparam int NG = CHUNK / 4;

  logic [CHUNK-1:0] p;
  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] c;
  logic [NG-1:0]    gp;
  logic [NG-1:0]    gg;
  logic [NG:0]      gc;

  // Carry into group j+1 as a flat sum of products over all lower groups,
  // so no group waits on the carry of its neighbour.
  function automatic logic group_carry(input int j, input logic [NG-1:0] gp_i,
                                       input logic [NG-1:0] gg_i, input logic cin_i);
    logic acc;
    logic term;
    acc = cin_i;
    for (int m = 0; m <= j; m++) acc = acc & gp_i[m];
    for (int i = 0; i <= j; i++) begin
      term = gg_i[i];
      for (int m = i + 1; m <= j; m++) term = term & gp_i[m];
      acc = acc | term;
    end
    return acc;
  endfunction

  assign p     = a ^ b;
  assign g     = a & b;
  assign gc[0] = cin;

  for (genvar j = 0; j < NG; j++) begin : g_grp
    localparam int B = 4 * j;

    assign gp[j] = &p[B +: 4];
    assign gg[j] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1]) |
                   (p[B+3] & p[B+2] & p[B+1] & g[B]);

    assign gc[j+1] = group_carry(j, gp, gg, cin);

    assign c[B]   = gc[j];
    assign c[B+1] = g[B] | (p[B] & gc[j]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[j]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B]) |
                    (p[B+2] & p[B+1] & p[B] & gc[j]);
  end

  assign sum   = p ^ c;
  assign cout  = gc[NG];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined CLA adder/subtractor: one CHUNK-bit slice resolved per stage,
// carry and operands skewed down the pipe, valid/ready on both ends.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int CHUNK = CLA_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NSTAGE = cla_nstage(WIDTH, CHUNK);

  if (!cla_params_ok(WIDTH, CHUNK)) begin : g_param_check
    $error("cla_adder_pipe: WIDTH must be a multiple of CHUNK, CHUNK a multiple of 4");
  end

  // Level k registers feed stage k; level NSTAGE is the output register.
  logic [NSTAGE:0]  vld;
  logic [NSTAGE:0]  cry;
  logic [WIDTH-1:0] opa  [NSTAGE];
  logic [WIDTH-1:0] opb  [NSTAGE];
  logic [WIDTH-1:0] psum [NSTAGE+1];
  logic             ovf_q;
  logic             zero_q;

  logic [CHUNK-1:0]  csum [NSTAGE];
  logic [NSTAGE-1:0] ccout;
  logic [NSTAGE-1:0] cmsb;
  logic [WIDTH-1:0]  nsum [NSTAGE];
  logic              adv;
  logic              ovf_next;
  logic              zero_next;
  logic              unused_cmsb;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    cla_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (opa[k][k*CHUNK +: CHUNK]),
      .b     (opb[k][k*CHUNK +: CHUNK]),
      .cin   (cry[k]),
      .sum   (csum[k]),
      .cout  (ccout[k]),
      .c_msb (cmsb[k])
    );
  end

  // Merge each stage's freshly resolved slice into the partial sum it carries.
  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      nsum[k] = psum[k];
      nsum[k][k*CHUNK +: CHUNK] = csum[k];
    end
  end

  // Overflow as carry-into-MSB xor carry-out, i.e. equal operand signs
  // (after B inversion) giving a sum of the other sign.
  assign ovf_next    = cmsb[NSTAGE-1] ^ ccout[NSTAGE-1];
  assign zero_next   = (nsum[NSTAGE-1] == '0);
  assign unused_cmsb = ^cmsb;

  // Whole pipe moves together on adv, bubbles included; everything holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= '0;
      cry    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
        opa[k] <= '0;
        opb[k] <= '0;
      end
      for (int k = 0; k <= NSTAGE; k++) psum[k] <= '0;
    end else if (adv) begin
      vld[0]  <= in_valid;
      opa[0]  <= in_a;
      opb[0]  <= in_b ^ {WIDTH{in_sub}};
      psum[0] <= '0;
      cry[0]  <= in_sub;
      for (int k = 0; k < NSTAGE; k++) begin
        vld[k+1]  <= vld[k];
        psum[k+1] <= nsum[k];
        cry[k+1]  <= ccout[k];
      end
      for (int k = 0; k < NSTAGE - 1; k++) begin
        opa[k+1] <= opa[k];
        opb[k+1] <= opb[k];
      end
      ovf_q  <= ovf_next;
      zero_q <= zero_next;
    end
  end

  assign out_valid = vld[NSTAGE];
  assign out_sum   = psum[NSTAGE];
  assign out_cout  = cry[NSTAGE];
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed and randomised checks for cla_adder_pipe (32/8 and 16/4 builds).
module tb_cla_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready;
  logic        out_cout, out_ovf, out_zero;
  logic [31:0] in_a, in_b, out_sum;

  logic        r_in_valid, r_in_ready, r_sub, r_out_valid, r_out_ready;
  logic        r_out_cout, r_out_ovf, r_out_zero;
  logic [15:0] r_a, r_b, r_out_sum;

  int checks = 0;
  int errors = 0;

  cla_adder_pipe #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  cla_adder_pipe #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(r_in_valid), .in_ready(r_in_ready),
    .in_a(r_a), .in_b(r_b), .in_sub(r_sub),
    .out_valid(r_out_valid), .out_ready(r_out_ready),
    .out_sum(r_out_sum), .out_cout(r_out_cout), .out_ovf(r_out_ovf), .out_zero(r_out_zero)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Offer one op at a negedge with out_ready high, then check latency and result.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic sub, input logic [31:0] es, input logic ec,
                               input logic eo, input logic ez);
    int lat;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'd4);
    checkOutput({tag, " sum"},  out_sum, es);
    checkOutput({tag, " cout"}, 32'(out_cout), 32'(ec));
    checkOutput({tag, " ovf"},  32'(out_ovf),  32'(eo));
    checkOutput({tag, " zero"}, 32'(out_zero), 32'(ez));
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Reference for the 16-bit build: {cout, ovf, zero, sum}.
  function automatic logic [18:0] model16(input logic [15:0] a, input logic [15:0] b, input logic sub);
    logic [15:0] be;
    logic [16:0] t;
    logic        ovf;
    be  = sub ? ~b : b;
    t   = {1'b0, a} + {1'b0, be} + 17'(sub);
    ovf = (a[15] == be[15]) && (t[15] != a[15]);
    return {t[16], ovf, (t[15:0] == 16'h0000), t[15:0]};
  endfunction

  logic [31:0] bpa [6] = '{32'h000000FF, 32'h0000FFFF, 32'h00FFFFFF,
                           32'hFFFFFFFF, 32'h80000000, 32'h12345678};
  logic [31:0] bpb [6] = '{32'h00000001, 32'h00000001, 32'h00000001,
                           32'h00000002, 32'h80000000, 32'h11111111};
  logic [31:0] bpe [6] = '{32'h00000100, 32'h00010000, 32'h01000000,
                           32'h00000001, 32'h00000000, 32'h23456789};
  logic [31:0] exp_q [$];
  logic [18:0] mq [$];
  int          idx, got, stall, sent, recv, wait_cnt;
  bit          seen;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
    r_in_valid = 1'b0; r_a = '0; r_b = '0; r_sub = 1'b0; r_out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_sum",   out_sum, 32'd0);
    checkOutput("reset flags",     {29'd0, out_cout, out_ovf, out_zero}, 32'd0);
    checkOutput("reset in_ready",  32'(in_ready), 32'd1);
    checkOutput("reset r16 valid", 32'(r_out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus("add wrap",  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    applyStimulus("sub ovf",   32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    applyStimulus("sub neg",   32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    applyStimulus("add ovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    applyStimulus("add mix",   32'h12345678, 32'h0FEDCBA9, 1'b0, 32'h22222221, 1'b0, 1'b0, 1'b0);
    applyStimulus("sub equal", 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);

    // Six back-to-back adds with a three-cycle output stall at the first result.
    idx = 0; got = 0; stall = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      in_valid = (idx < 6);
      in_sub   = 1'b0;
      if (idx < 6) begin
        in_a = bpa[idx];
        in_b = bpb[idx];
      end
      if (out_valid && !seen) begin
        seen  = 1'b1;
        stall = 3;
      end
      out_ready = (stall == 0);
      #1;
      if (stall > 0) begin
        checkOutput("bp in_ready low", 32'(in_ready), 32'd0);
        if (exp_q.size() != 0) checkOutput("bp sum hold", out_sum, exp_q[0]);
        stall--;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(bpe[idx]);
        idx++;
      end
      if (out_valid && out_ready) begin
        checkOutput("bp spurious", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) checkOutput("bp order", out_sum, exp_q.pop_front());
        got++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("bp count", 32'(got), 32'd6);
    @(negedge clk);

    // Three ops in flight with the output blocked, then reset.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 32'hFFFFFFFF; in_b = 32'(i + 1) + 32'hFFFFFFFE; in_sub = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    checkOutput("rst pre valid", 32'(out_valid), 32'd1);
    checkOutput("rst pre sum",   out_sum, 32'hFFFFFFFE);
    rst_n = 1'b0;
    #1;
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst out_sum",   out_sum, 32'd0);
    checkOutput("rst flags",     {29'd0, out_cout, out_ovf, out_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    applyStimulus("post rst", 32'h000000FF, 32'h00000F01, 1'b0, 32'h00001000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // 16-bit build: random add/sub with random backpressure against the model.
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
      r_in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
      r_a         = pick16();
      r_b         = pick16();
      r_sub       = 1'($urandom_range(1));
      r_out_ready = ($urandom_range(9) < 7);
      #1;
      checkOutput("r16 in_ready", 32'(r_in_ready), 32'(!r_out_valid || r_out_ready));
      if (r_in_valid && r_in_ready) begin
        mq.push_back(model16(r_a, r_b, r_sub));
        sent++;
      end
      if (r_out_valid && r_out_ready) begin
        checkOutput("r16 spurious", 32'(mq.size() != 0), 32'd1);
        if (mq.size() != 0)
          checkOutput("r16 result", {13'd0, r_out_cout, r_out_ovf, r_out_zero, r_out_sum},
                      {13'd0, mq.pop_front()});
        recv++;
      end
      @(negedge clk);
    end
    r_in_valid = 1'b0;
    checkOutput("r16 count", 32'(recv), 32'd1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath. It generalises the 4-bit CLA group to WIDTH bits.
- Carry propagates through one pipeline register per CHUNK-bit slice. Each slice is computed with two-level lookahead: 4-bit group P/G, then slice-level carry.
- Valid/ready handshake on input and output, full backpressure, throughput of one operation per cycle.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits resolved per pipeline stage; must be a multiple of 4.
- NSTAGE, WIDTH/CHUNK, derived pipeline depth; not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  block accepts the operation this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_sub  in  1  0 = A+B, 1 = A-B
- out_valid  out  1  result present
- out_ready  in  1  consumer takes the result this cycle
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of MSB; for subtract, 1 = no borrow
- out_ovf  out  1  signed two's-complement overflow
- out_zero  out  1  out_sum == 0

Behaviour:
- Reset (asynchronous assert, synchronous release via clk edge): all stage valid bits, out_valid, out_sum, out_cout, out_ovf and out_zero are 0. Stage data registers are cleared to 0.
- Subtract: B is inverted and carry-in is 1 (A + ~B + 1). Add: carry-in is 0.
- Global advance: adv = !out_valid | out_ready. in_ready = adv, combinational from out_valid/out_ready only, never from in_valid.
- Accept occurs when in_valid & in_ready.
- Stage k (0..NSTAGE-1) computes sum bits [k*CHUNK +: CHUNK] from the carry registered by stage k-1 (stage 0 uses the subtract carry-in). Internally each stage is 4-bit groups with group P/G and lookahead across groups; no ripple across groups within a stage.
- Operand skew: untouched upper operand bits, the partial sum so far, the inter-stage carry, the op's sign bits and the valid bit all travel with the operation down the pipe.
- Latency: an op accepted at edge N has out_valid = 1 after edge N+NSTAGE, provided out_ready is high throughout.
- When adv = 0, every stage register, including the output, holds. out_sum, out_cout, out_ovf and out_zero stay stable while out_valid & !out_ready.
- When adv = 1, bubbles advance too. A stage with valid = 0 propagates valid = 0; its data is don't-care but deterministic.
- Ordering: results leave in accept order. No drop, no duplication.
- Flags:
  - out_ovf = (a_msb == b_eff_msb) & (sum_msb != a_msb), where b_eff is the post-inversion B.
  - out_zero is computed in the final stage.
  - Flags are registered with out_sum.
- Simultaneous out_ready and in_valid with a full pipe: output pops and input is accepted in the same cycle.
- Reset mid-operation: all in-flight ops are discarded and out_valid drops at once.
- Wrap-around: the sum is modulo 2^WIDTH; carry is reported only via out_cout.

Decomposition:
- Package cla_pkg: default WIDTH and CHUNK constants; a function giving NSTAGE; an elaboration check that WIDTH % CHUNK == 0 and CHUNK % 4 == 0.
- Sub-module cla_chunk (purely combinational, CHUNK parameter): inputs a, b, cin; outputs sum, cout, and msb-carry-in for overflow. It instantiates CHUNK/4 4-bit lookahead groups plus the group-level carry logic.
- cla_adder_pipe holds all registers and the handshake logic.

Test Plan (WIDTH=32, CHUNK=8, latency 4 unless noted):
- Add 0xFFFFFFFF + 0x00000001, out_ready = 1 -> 4 cycles later: sum 0x00000000, cout 1, zero 1, ovf 0.
- Sub 0x80000000 - 0x00000001 -> sum 0x7FFFFFFF, cout 1, ovf 1, zero 0. Then sub 5 - 7 -> sum 0xFFFFFFFE, cout 0, ovf 0.
- Add 0x7FFFFFFF + 1 -> sum 0x80000000, ovf 1, cout 0. Add 0x12345678 + 0x0FEDCBA9 -> 0x22222221, cout 0.
- Issue 6 back-to-back ops; hold out_ready low for 3 cycles once the first result appears -> in_ready low in those cycles, out_sum stable, all 6 results in order, none lost.
- Assert rst_n low with 3 ops in flight -> out_valid 0 immediately, all outputs 0. After release, the next op's result is correct with latency 4 and no stale result appears.
- WIDTH=16, CHUNK=4 (latency 4): 1000 random add/sub ops with random out_ready -> every output matches the scoreboard model, including cout, ovf and zero.
